player_bullet_pool: RTL and testbench
=====================================

PLAYER_BULLET_POOL -- requirements
Module: player_bullet_pool

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port tick, input, 1, frame-advance enable; bullet motion, firing and cooldown act only in cycles with tick=1.
REQ-004 SHALL have port attack, input, 1, player fire request (level).
REQ-005 SHALL have port defend, input, 1, player defending; blocks firing.
REQ-006 SHALL have ports xPlayer, input, signed 11 and yPlayer, input, signed 10, player centre.
REQ-007 SHALL have ports xEnemy, input, signed 11 and yEnemy, input, signed 10, enemy centre.
REQ-008 SHALL have port enemySquat, input, 1, enemy squatting; selects the enemy hitbox half-height.
REQ-009 SHALL have ports x[0:3], output, signed 11 and y[0:3], output, signed 10, per-slot bullet centre (registered).
REQ-010 SHALL have port isE[0:3], output, 1 each, per-slot bullet-exists flag (registered).
REQ-011 SHALL have port isHit, output, 1, registered one-cycle pulse: at least one bullet hit the enemy on the preceding tick.
REQ-012 SHALL have port hitCnt, output, 3, registered count (0-4) of hits on the preceding tick; 0 when isHit=0.

Function
REQ-013 SHALL keep each of GOOD_BULLET_SLOTS=4 slots in state IDLE (isE=0) or FLY (isE=1).
REQ-014 SHALL, on a tick, move every FLY slot: x_next = x + BULLET_STEP_X, y unchanged; hit/exit tests use x_next.
REQ-015 SHALL flag a hit when x_next + BULLET_X > xEnemy - PLAYER_X AND y - BULLET_Y < yEnemy + H AND y + BULLET_Y > yEnemy - H, H = enemySquat ? SQUAT_PLAYER_Y : PLAYER_Y.
REQ-016 SHALL return a hit slot to IDLE and count it in hitCnt.
REQ-017 SHALL return a slot to IDLE without counting when x_next > MAP_X - BULLET_X and no hit; on both, hit wins.
REQ-018 SHALL, on a tick with attack=1, defend=0, cooldown=0 and at least one slot IDLE at tick start, spawn into the lowest-index IDLE slot: x = xPlayer + PLAYER_X + BULLET_X, y = yPlayer, FLY.
REQ-019 SHALL NOT reuse a slot freed on the same tick for that tick's spawn; no spawn when all four are FLY (request dropped, cooldown unchanged).
REQ-020 SHALL not move or hit-test a newly spawned bullet on its spawn tick.
REQ-021 SHALL keep a 4-bit cooldown counter: loaded with FIRE_COOLDOWN=8 on spawn, else decremented on each tick while nonzero; saturates at 0.
REQ-022 SHALL hold all state when tick=0; isHit/hitCnt SHALL be 0 in any cycle not immediately following a tick.
REQ-023 SHALL perform all position arithmetic in signed 12-bit to avoid overflow, truncating stored values to port widths.

Reset
REQ-024 SHALL, while rst_n=0, force isE=0, x=0, y=0 for all slots, cooldown=0, isHit=0, hitCnt=0, independent of clk.
REQ-025 SHALL discard in-flight bullets on reset mid-operation; first spawn possible on the first tick after release.

Structure
REQ-026 SHALL take BULLET_STEP_X, BULLET_X, BULLET_Y, PLAYER_X, PLAYER_Y, SQUAT_PLAYER_Y, MAP_X from GamePkg and add GOOD_BULLET_SLOTS and FIRE_COOLDOWN there.
REQ-027 SHALL instantiate sub-module good_bullet_slot x4 (per-slot state, motion, hit/exit test); allocation, cooldown and hit counting stay in the top.

Verification (bench constants: BULLET_STEP_X=8, BULLET_X=4, BULLET_Y=4, PLAYER_X=16, PLAYER_Y=32, SQUAT_PLAYER_Y=16, MAP_X=320)
REQ-028 Fire: xPlayer=-200, yPlayer=0, attack=1 one tick -> slot0 isE=1, x=-180, y=0; next tick x=-172; cooldown blocks slots 1 until 8 ticks later.
REQ-029 Hit: xEnemy=100, yEnemy=0, bullet at y=0 -> first tick with x_next>80 clears slot, isHit=1 and hitCnt=1 for one cycle.
REQ-030 Squat miss: yEnemy=0, enemySquat=1, bullet y=24 -> passes enemy, retires at x_next>316 with isHit never asserted; enemySquat=0 same case -> hit.
REQ-031 Pool full: attack held with FIRE_COOLDOWN elapsed, 4 bullets flying, no enemy overlap -> 5th request dropped; after slot0 exits, next fire uses slot0.
REQ-032 Simultaneous: two bullets cross enemy edge on same tick -> hitCnt=2, isHit=1 once; defend=1 with attack=1 -> no spawn.
REQ-033 Reset mid-flight: rst_n low with 3 bullets in flight -> all isE=0, x=y=0 immediately; isHit=0.

Source files
------------

// File: rtl/player_bullet_pool_pkg.sv
// GamePkg: shared game geometry plus the player bullet pool parameters.
// Geometry constants are signed 12-bit so every position calculation is done
// one bit wider than the widest port and cannot overflow.
package GamePkg;

  localparam logic signed [11:0] BULLET_STEP_X  = 12'sd8;
  localparam logic signed [11:0] BULLET_X       = 12'sd4;
  localparam logic signed [11:0] BULLET_Y       = 12'sd4;
  localparam logic signed [11:0] PLAYER_X       = 12'sd16;
  localparam logic signed [11:0] PLAYER_Y       = 12'sd32;
  localparam logic signed [11:0] SQUAT_PLAYER_Y = 12'sd16;
  localparam logic signed [11:0] MAP_X          = 12'sd320;

  localparam int               GOOD_BULLET_SLOTS = 4;
  localparam logic [3:0]       FIRE_COOLDOWN     = 4'd8;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_e;

  // Sign-extend an 11-bit x coordinate to the 12-bit arithmetic width.
  function automatic logic signed [11:0] sx11(input logic signed [10:0] v);
    return {v[10], v};
  endfunction

  // Sign-extend a 10-bit y coordinate to the 12-bit arithmetic width.
  function automatic logic signed [11:0] sx10(input logic signed [9:0] v);
    return {{2{v[9]}}, v};
  endfunction

endpackage

// File: rtl/player_bullet_pool_slot.sv
// good_bullet_slot: one player bullet. Holds IDLE/FLY state and position,
// advances the bullet on each tick, tests the advanced position against the
// enemy hitbox and the right map edge, and retires the bullet on either.
// Ports: clk, rst_n, tick_i, spawn_i/spawn_x_i/spawn_y_i (load request, only
// honoured when IDLE), xEnemy_i/yEnemy_i/enemySquat_i (target), x_o/y_o/is_e_o
// (registered slot state), hit_o (combinational, this tick's hit).
module good_bullet_slot
  import GamePkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               spawn_i,
  input  logic signed [10:0] spawn_x_i,
  input  logic signed [9:0]  spawn_y_i,
  input  logic signed [10:0] xEnemy_i,
  input  logic signed [9:0]  yEnemy_i,
  input  logic               enemySquat_i,
  output logic signed [10:0] x_o,
  output logic signed [9:0]  y_o,
  output logic               is_e_o,
  output logic               hit_o
);

  slot_state_e        state_q, state_d;
  logic signed [10:0] x_q, x_d;
  logic signed [9:0]  y_q, y_d;

  logic signed [11:0] x_next_s;
  logic signed [11:0] y_s;
  logic signed [11:0] ye_s;
  logic signed [11:0] half_h_s;
  logic               hit_c_s;
  logic               exit_c_s;

  // Hitbox / exit tests use the already-advanced x; hit has priority over exit.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hit_o    = 1'b0;
    x_next_s = sx11(x_q) + BULLET_STEP_X;
    y_s      = sx10(y_q);
    ye_s     = sx10(yEnemy_i);
    half_h_s = enemySquat_i ? SQUAT_PLAYER_Y : PLAYER_Y;
    hit_c_s  = (x_next_s + BULLET_X > sx11(xEnemy_i) - PLAYER_X) &&
               (y_s - BULLET_Y < ye_s + half_h_s) &&
               (y_s + BULLET_Y > ye_s - half_h_s);
    exit_c_s = (x_next_s > MAP_X - BULLET_X);
    if (tick_i) begin
      case (state_q)
        SLOT_FLY: begin
          x_d   = x_next_s[10:0];
          hit_o = hit_c_s;
          if (hit_c_s || exit_c_s) begin
            state_d = SLOT_IDLE;
          end else begin
            state_d = SLOT_FLY;
          end
        end
        SLOT_IDLE: begin
          // A fresh bullet is neither moved nor tested on its spawn tick.
          if (spawn_i) begin
            state_d = SLOT_FLY;
            x_d     = spawn_x_i;
            y_d     = spawn_y_i;
          end else begin
            state_d = SLOT_IDLE;
          end
        end
        default: state_d = SLOT_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Slot state and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      x_q     <= 11'sd0;
      y_q     <= 10'sd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign is_e_o = (state_q == SLOT_FLY);

endmodule

// File: rtl/player_bullet_pool.sv
// player_bullet_pool: pool of four player bullets. Allocates new bullets to
// the lowest free slot subject to a fire cooldown, and reports how many
// bullets hit the enemy on the previous tick.
// Ports: clk, rst_n, tick (frame enable), attack/defend (fire control),
// xPlayer/yPlayer, xEnemy/yEnemy/enemySquat (positions), x/y/isE per slot
// (registered), isHit/hitCnt (registered hit report for the preceding tick).
module player_bullet_pool
  import GamePkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               attack,
  input  logic               defend,
  input  logic signed [10:0] xPlayer,
  input  logic signed [9:0]  yPlayer,
  input  logic signed [10:0] xEnemy,
  input  logic signed [9:0]  yEnemy,
  input  logic               enemySquat,
  output logic signed [10:0] x [0:3],
  output logic signed [9:0]  y [0:3],
  output logic               isE [0:3],
  output logic               isHit,
  output logic [2:0]         hitCnt
);

  logic [3:0]         cd_q, cd_d;
  logic               is_hit_q, is_hit_d;
  logic [2:0]         hit_cnt_q, hit_cnt_d;

  logic [3:0]         spawn_s;
  logic [3:0]         hit_s;
  logic               fire_ok_s;
  logic               any_idle_s;
  logic               found_s;
  logic signed [11:0] spawn_x12_s;

  for (genvar g = 0; g < GOOD_BULLET_SLOTS; g++) begin : g_slot
    good_bullet_slot u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_i       (tick),
      .spawn_i      (spawn_s[g]),
      .spawn_x_i    (spawn_x12_s[10:0]),
      .spawn_y_i    (yPlayer),
      .xEnemy_i     (xEnemy),
      .yEnemy_i     (yEnemy),
      .enemySquat_i (enemySquat),
      .x_o          (x[g]),
      .y_o          (y[g]),
      .is_e_o       (isE[g]),
      .hit_o        (hit_s[g])
    );
  end

  // Allocation, cooldown and hit counting. Free slots are judged on the
  // registered isE, so a slot retiring this tick is not reused until the next.
  always_comb begin
    spawn_s     = 4'b0000;
    found_s     = 1'b0;
    any_idle_s  = 1'b0;
    hit_cnt_d   = 3'd0;
    spawn_x12_s = sx11(xPlayer) + PLAYER_X + BULLET_X;
    for (int i = 0; i < GOOD_BULLET_SLOTS; i++) begin
      if (!isE[i]) begin
        any_idle_s = 1'b1;
      end else begin
        any_idle_s = any_idle_s;
      end
    end
    fire_ok_s = tick && attack && !defend && (cd_q == 4'd0) && any_idle_s;
    for (int i = 0; i < GOOD_BULLET_SLOTS; i++) begin
      if (fire_ok_s && !isE[i] && !found_s) begin
        spawn_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        spawn_s[i] = spawn_s[i];
      end
      hit_cnt_d = hit_cnt_d + {2'b00, hit_s[i]};
    end
    is_hit_d = (hit_cnt_d != 3'd0);
    if (fire_ok_s) begin
      cd_d = FIRE_COOLDOWN;
    end else if (tick && (cd_q != 4'd0)) begin
      cd_d = cd_q - 4'd1;
    end else begin
      cd_d = cd_q;
    end
  end

  // Cooldown and hit report registers; hit_s is already zero off-tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q      <= 4'd0;
      is_hit_q  <= 1'b0;
      hit_cnt_q <= 3'd0;
    end else begin
      cd_q      <= cd_d;
      is_hit_q  <= is_hit_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign isHit  = is_hit_q;
  assign hitCnt = hit_cnt_q;

endmodule

// File: tb/tb_player_bullet_pool.sv
// Self-checking bench for player_bullet_pool: a slot-list model written
// directly from the game rules, compared every cycle, plus literal scenarios.
module tb_player_bullet_pool;

  localparam int STEP = 8, BX = 4, BY = 4, PX = 16, PY = 32, SPY = 16, MAPX = 320, COOL = 8;

  logic clk, rst_n, tick, attack, defend, enemySquat;
  logic signed [10:0] xPlayer, xEnemy;
  logic signed [9:0]  yPlayer, yEnemy;
  logic signed [10:0] x [0:3];
  logic signed [9:0]  y [0:3];
  logic               isE [0:3];
  logic               isHit;
  logic [2:0]         hitCnt;

  int  npass, ntot;
  bit  chk_en;

  // Reference model state
  bit  mex [4];
  int  mx [4];
  int  my [4];
  int  mcd, mcnt;
  bit  mhit;

  player_bullet_pool dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .attack(attack), .defend(defend),
    .xPlayer(xPlayer), .yPlayer(yPlayer), .xEnemy(xEnemy), .yEnemy(yEnemy),
    .enemySquat(enemySquat), .x(x), .y(y), .isE(isE), .isHit(isHit), .hitCnt(hitCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule-level model: list of flying bullets, free-slot scan, cooldown counter.
  always @(posedge clk or negedge rst_n) begin : model
    int cnt, fidx, xn, h;
    bit fire;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mex[i] <= 1'b0; mx[i] <= 0; my[i] <= 0;
      end
      mcd <= 0; mhit <= 1'b0; mcnt <= 0;
    end else if (tick) begin
      cnt = 0; fidx = -1;
      for (int i = 3; i >= 0; i--) if (!mex[i]) fidx = i;
      fire = attack && !defend && (mcd == 0) && (fidx >= 0);
      h = enemySquat ? SPY : PY;
      for (int i = 0; i < 4; i++) begin
        if (mex[i]) begin
          xn = mx[i] + STEP;
          if ((xn + BX > int'(xEnemy) - PX) && (my[i] - BY < int'(yEnemy) + h) && (my[i] + BY > int'(yEnemy) - h)) begin
            cnt++;
            mex[i] <= 1'b0;
          end else if (xn > MAPX - BX) begin
            mex[i] <= 1'b0;
          end
          mx[i] <= xn;
        end
      end
      if (fire) begin
        mex[fidx] <= 1'b1; mx[fidx] <= int'(xPlayer) + PX + BX; my[fidx] <= int'(yPlayer);
      end
      mcd  <= fire ? COOL : ((mcd > 0) ? mcd - 1 : 0);
      mhit <= (cnt > 0);
      mcnt <= cnt;
    end else begin
      mhit <= 1'b0;
      mcnt <= 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of all outputs against the model.
  task automatic compare_model();
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("isE[%0d]", i), int'(isE[i]), int'(mex[i]));
        if (mex[i] || !rst_n) begin
          chk($sformatf("x[%0d]", i), int'(x[i]), mx[i]);
          chk($sformatf("y[%0d]", i), int'(y[i]), my[i]);
        end
      end
      chk("isHit", int'(isHit), int'(mhit));
      chk("hitCnt", int'(hitCnt), mcnt);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then drive tick.
  task automatic cyc(input logic t);
    @(negedge clk);
    compare_model();
    tick = t;
  endtask

  task automatic tick1();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
  endtask

  initial begin
    bit sawhit;
    npass = 0; ntot = 0; chk_en = 1'b0;
    rst_n = 1'b0; tick = 1'b0; attack = 1'b0; defend = 1'b0; enemySquat = 1'b0;
    xPlayer = 11'sd0; yPlayer = 10'sd0; xEnemy = 11'sd1000; yEnemy = 10'sd400;
    cyc(1'b0); cyc(1'b0);
    chk_en = 1'b1;
    do_reset();
    chk("reset_isE0", int'(isE[0]), 0);
    chk("reset_hitCnt", int'(hitCnt), 0);

    // Fire and cooldown
    attack = 1'b1; xPlayer = -11'sd200; yPlayer = 10'sd0;
    tick1();
    chk("fire_isE0", int'(isE[0]), 1);
    chk("fire_x0", int'(x[0]), -180);
    chk("fire_y0", int'(y[0]), 0);
    attack = 1'b0;
    tick1();
    chk("move_x0", int'(x[0]), -172);
    attack = 1'b1;
    repeat (7) tick1();
    chk("cool_block_isE1", int'(isE[1]), 0);
    tick1();
    chk("cool_done_isE1", int'(isE[1]), 1);
    chk("cool_done_x1", int'(x[1]), -180);
    chk("cool_done_x0", int'(x[0]), -108);
    attack = 1'b0;

    // Hit on enemy at x=100
    do_reset();
    xEnemy = 11'sd100; yEnemy = 10'sd0; xPlayer = 11'sd0; yPlayer = 10'sd0;
    attack = 1'b1; tick1(); attack = 1'b0;
    repeat (7) tick1();
    chk("prehit_x0", int'(x[0]), 76);
    chk("prehit_isHit", int'(isHit), 0);
    tick1();
    chk("hit_isHit", int'(isHit), 1);
    chk("hit_hitCnt", int'(hitCnt), 1);
    chk("hit_isE0", int'(isE[0]), 0);
    cyc(1'b0);
    chk("hit_pulse_end", int'(isHit), 0);

    // Squatting enemy: bullet at y=24 passes over
    do_reset();
    enemySquat = 1'b1; yPlayer = 10'sd24;
    attack = 1'b1; tick1(); attack = 1'b0;
    sawhit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick1();
      if (isHit) sawhit = 1'b1;
    end
    chk("squat_nohit", int'(sawhit), 0);
    chk("squat_exit_isE0", int'(isE[0]), 0);
    enemySquat = 1'b0;
    attack = 1'b1; tick1(); attack = 1'b0;
    repeat (8) tick1();
    chk("stand_hitCnt", int'(hitCnt), 1);

    // Pool full, enemy far away
    do_reset();
    xEnemy = 11'sd1000; yEnemy = 10'sd400; xPlayer = 11'sd0; yPlayer = 10'sd0;
    attack = 1'b1;
    repeat (38) tick1();
    chk("full_isE", int'({isE[0], isE[1], isE[2], isE[3]}), 15);
    tick1();
    chk("full_exit_isE0", int'(isE[0]), 0);
    chk("full_exit_isE3", int'(isE[3]), 1);
    tick1();
    chk("reuse_isE0", int'(isE[0]), 1);
    chk("reuse_x0", int'(x[0]), 20);
    attack = 1'b0;

    // Two bullets crossing the enemy edge together, then defend blocks fire
    do_reset();
    xEnemy = 11'sd300; yEnemy = 10'sd0; xPlayer = 11'sd0;
    attack = 1'b1; tick1(); attack = 1'b0;
    repeat (8) tick1();
    xPlayer = 11'sd72; attack = 1'b1; tick1(); attack = 1'b0;
    chk("pair_x0", int'(x[0]), 92);
    chk("pair_x1", int'(x[1]), 92);
    repeat (23) tick1();
    chk("pair_prehit", int'(isHit), 0);
    tick1();
    chk("pair_isHit", int'(isHit), 1);
    chk("pair_hitCnt", int'(hitCnt), 2);
    cyc(1'b0);
    chk("pair_once", int'(isHit), 0);
    defend = 1'b1; attack = 1'b1; tick1();
    chk("defend_isE0", int'(isE[0]), 0);
    defend = 1'b0; attack = 1'b0;

    // Reset with three bullets in flight
    do_reset();
    xEnemy = 11'sd1000; yEnemy = 10'sd400; xPlayer = 11'sd10; yPlayer = 10'sd50;
    attack = 1'b1;
    repeat (19) tick1();
    chk("mid_isE2", int'(isE[2]), 1);
    attack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_isE", int'({isE[0], isE[1], isE[2], isE[3]}), 0);
    chk("rst_x0", int'(x[0]), 0);
    chk("rst_y1", int'(y[1]), 0);
    chk("rst_isHit", int'(isHit), 0);
    cyc(1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
    attack = 1'b1; tick1(); attack = 1'b0;
    chk("post_rst_fire", int'(isE[0]), 1);
    chk("post_rst_x0", int'(x[0]), 30);
    cyc(1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
